fifo_pkt_reader: RTL and testbench

- Drains packets from the read side of a first-word-fall-through synchronous FIFO: `dout` valid whenever `empty` is low; a word is consumed by asserting `rd_en`.
- Each packet in the FIFO is one header word followed by LEN payload words.
- The block strips the header and emits the payload on a valid/ready stream with sop/eop and destination port tags. Malformed packets are dropped.
- It sits between each input-port FIFO and the cache write arbiter.

---
 rtl/fifo_pkt_reader_pkg.sv | 27 ++
 rtl/fifo_pkt_reader_if.sv | 28 ++
 rtl/fifo_pkt_reader_skid_buf.sv | 48 ++++
 rtl/fifo_pkt_reader.sv | 138 +++++++++++++
 tb/tb_fifo_pkt_reader.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkt_reader_pkg.sv
// Shared types for the FIFO packet reader: FSM states,
// header field layout and the skid-buffer entry.
package fifo_pkt_reader_pkg;

  localparam int PKT_DATA_W  = 32;
  localparam int PKT_LEN_W   = 16;
  localparam int PKT_DEST_W  = 4;
  localparam int PKT_MAX_LEN = 256;
  localparam int PKT_CNT_W   = 16;

  localparam int HDR_LEN_LSB  = 0;
  localparam int HDR_DEST_LSB = PKT_LEN_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } state_t;

  typedef struct packed {
    logic [PKT_DATA_W-1:0] data;
    logic                  sop;
    logic                  eop;
    logic [PKT_DEST_W-1:0] dest;
  } skid_ent_t;

endpackage

// File: rtl/fifo_pkt_reader_if.sv
// FIFO read side plus output beat stream.
// master: the reader; slave: FIFO and downstream.
interface fifo_pkt_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_W     = 4
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_empty;
  logic                  in_rd_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sop;
  logic                  out_eop;
  logic [DEST_W-1:0]     out_dest;

  modport master (
    input  in_data, in_empty, out_ready,
    output in_rd_en, out_valid, out_data,
    output out_sop, out_eop, out_dest
  );

  modport slave (
    output in_data, in_empty, out_ready,
    input  in_rd_en, out_valid, out_data,
    input  out_sop, out_eop, out_dest
  );
endinterface

// File: rtl/fifo_pkt_reader_skid_buf.sv
// 2-entry in-order register buffer, valid/ready out.
// Ports: push_i/din_i in, pop_i/dout_o/valid_o/cnt_o out.
module pkt_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic [1:0]   cnt_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         pop;

  assign pop     = pop_i & (cnt_q != 2'd0);
  assign dout_o  = mem_q[rd_q];
  assign valid_o = (cnt_q != 2'd0);
  assign cnt_o   = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      unique case ({push_i, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fifo_pkt_reader.sv
// Strips packet headers from an FWFT FIFO and streams payload.
// Ports: clk, rst, bus (master), pkt_cnt, err_cnt, busy.
module fifo_pkt_reader
  import fifo_pkt_reader_pkg::*;
#(
  parameter int DATA_WIDTH = PKT_DATA_W,
  parameter int LEN_W      = PKT_LEN_W,
  parameter int DEST_W     = PKT_DEST_W,
  parameter int MAX_LEN    = PKT_MAX_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_pkt_reader_if.master    bus,
  output logic [PKT_CNT_W-1:0] pkt_cnt,
  output logic [PKT_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic                 first_q, first_d;
  logic [DEST_W-1:0]    dest_q, dest_d;
  logic [PKT_CNT_W-1:0] pkt_q, err_q;
  logic                 pkt_inc, err_inc;
  logic                 rd_en, pop, push;
  logic [1:0]           skid_cnt;
  logic                 skid_valid;
  skid_ent_t            ent, head;
  logic [LEN_W-1:0]     hdr_len;
  logic [DEST_W-1:0]    hdr_dest;
  logic                 last;

  assign hdr_len  = bus.in_data[HDR_LEN_LSB +: LEN_W];
  assign hdr_dest = bus.in_data[HDR_DEST_LSB +: DEST_W];
  assign last     = (rem_q == LEN_W'(1));
  assign pop      = rd_en & ~bus.in_empty;

  // Reset gates the read so the FIFO is left untouched.
  always_comb begin
    rd_en = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE:    rd_en = ~bus.in_empty;
        PAYLOAD: rd_en = ~bus.in_empty & (skid_cnt < 2'd2);
        DROP:    rd_en = ~bus.in_empty;
        default: rd_en = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    first_d  = first_q;
    dest_d   = dest_q;
    push     = 1'b0;
    pkt_inc  = 1'b0;
    err_inc  = 1'b0;
    ent.data = bus.in_data;
    ent.sop  = first_q;
    ent.eop  = last;
    ent.dest = dest_q;
    if (pop) begin
      unique case (state_q)
        IDLE: begin
          dest_d = hdr_dest;
          if (hdr_len == '0) begin
            err_inc = 1'b1;
          end else if (hdr_len > LEN_W'(MAX_LEN)) begin
            err_inc = 1'b1;
            rem_d   = hdr_len;
            state_d = DROP;
          end else begin
            rem_d   = hdr_len;
            first_d = 1'b1;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          push    = 1'b1;
          rem_d   = rem_q - LEN_W'(1);
          first_d = 1'b0;
          if (last) begin
            pkt_inc = 1'b1;
            state_d = IDLE;
          end
        end
        DROP: begin
          rem_d = rem_q - LEN_W'(1);
          if (last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      first_q <= 1'b0;
      dest_q  <= '0;
      pkt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      dest_q  <= dest_d;
      if (pkt_inc) pkt_q <= pkt_q + 1'b1;
      if (err_inc && err_q != '1) err_q <= err_q + 1'b1;
    end
  end

  pkt_skid_buf #(
    .W($bits(skid_ent_t))
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (ent),
    .pop_i   (bus.out_ready),
    .dout_o  (head),
    .valid_o (skid_valid),
    .cnt_o   (skid_cnt)
  );

  assign bus.in_rd_en  = rd_en;
  assign bus.out_valid = skid_valid;
  assign bus.out_data  = head.data;
  assign bus.out_sop   = head.sop;
  assign bus.out_eop   = head.eop;
  assign bus.out_dest  = head.dest;
  assign pkt_cnt       = pkt_q;
  assign err_cnt       = err_q;
  assign busy          = (state_q != IDLE) | skid_valid;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: FIFO model, scoreboard queue,
// negedge monitor.
module tb_fifo_pkt_reader;
  import fifo_pkt_reader_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        e;
    logic [3:0]  dest;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pops = 0;
  bit          gap_en = 0;
  bit          gap_q = 0;
  bit          pop_ne = 0;
  logic [31:0] fq[$];
  beat_t       exp_q[$];
  int          beat_cyc[$];
  beat_t       prev;
  bit          prev_stall = 0;

  always #5 clk = ~clk;

  fifo_pkt_reader_if #(.DATA_WIDTH(32), .DEST_W(4)) bus ();

  fifo_pkt_reader dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .pkt_cnt (pkt_cnt),
    .err_cnt (err_cnt),
    .busy    (busy)
  );

  // FIFO model: pop decided at negedge, applied after posedge.
  always @(negedge clk) begin
    pop_ne = (bus.in_rd_en === 1'b1) && !bus.in_empty;
    if (!rst && bus.in_empty && bus.in_rd_en !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL rd_en_on_empty act=%b req=0", bus.in_rd_en);
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (pop_ne) begin
      if (fq.size() != 0) void'(fq.pop_front());
      pops++;
    end
    gap_q = gap_en ? ~gap_q : 1'b0;
    bus.in_empty = (fq.size() == 0) || gap_q;
    bus.in_data  = (fq.size() != 0) ? fq[0] : 32'h0;
  end

  // Monitor: compare each accepted beat with the scoreboard.
  always @(negedge clk) begin
    beat_t cur, e;
    cur = '{bus.out_data, bus.out_sop, bus.out_eop, bus.out_dest};
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!bus.out_valid || cur != prev) begin
          errors++;
          $display("FAIL hold act=%b/%h req=1/%h",
                   bus.out_valid, cur, prev);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat unexpected act=%h req=none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur != e) begin
            errors++;
            $display("FAIL beat act d=%h s=%b e=%b dst=%h req d=%h s=%b e=%b dst=%h",
                     cur.d, cur.s, cur.e, cur.dest,
                     e.d, e.s, e.e, e.dest);
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev       = cur;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic hdr(input logic [3:0] d, input logic [15:0] l);
    fq.push_back({12'h0, d, l});
  endtask

  task automatic word(input logic [31:0] w, input bit s,
                      input bit e, input logic [3:0] d,
                      input bit ex);
    fq.push_back(w);
    if (ex) exp_q.push_back('{w, s, e, d});
  endtask

  task automatic wait_idle(input string nm, input int max);
    int n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || busy !== 1'b0)
           && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL %s timeout act=%0d req<%0d", nm, n, max);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst           = 1'b1;
    bus.in_empty  = 1'b1;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset with a non-empty FIFO; packet held for after.
    hdr(4'd5, 16'd3);
    word(32'hA, 1, 0, 4'd5, 1);
    word(32'hB, 0, 0, 4'd5, 1);
    word(32'hC, 0, 1, 4'd5, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", bus.in_rd_en, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_pkt", pkt_cnt, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_untouched", pops, 0);

    // Simple 3-word packet, ready held high.
    @(posedge clk);
    #1 rst = 1'b0;
    wait_idle("t2", 100);
    chk("t2_pkt", pkt_cnt, 1);
    chk("t2_nbeats", beat_cyc.size(), 3);
    if (beat_cyc.size() == 3)
      chk("t2_consec", beat_cyc[2] - beat_cyc[0], 2);

    // Backpressure: ready low 6 cycles from first beat.
    do_reset(1);
    @(negedge clk);
    pops = 0;
    bus.out_ready = 1'b0;
    hdr(4'd5, 16'd3);
    word(32'hA, 1, 0, 4'd5, 1);
    word(32'hB, 0, 0, 4'd5, 1);
    word(32'hC, 0, 1, 4'd5, 1);
    hdr(4'd9, 16'd4);
    word(32'h10, 1, 0, 4'd9, 1);
    word(32'h11, 0, 0, 4'd9, 1);
    word(32'h12, 0, 0, 4'd9, 1);
    word(32'h13, 0, 1, 4'd9, 1);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t3_first_valid", bus.out_valid, 1);
    repeat (3) @(negedge clk);
    chk("t3_rd_en_stall", bus.in_rd_en, 0);
    chk("t3_pops_stall", pops, 3);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_idle("t3", 200);
    chk("t3_pkt", pkt_cnt, 2);

    // len=0, oversized len=257, then a 1-word packet.
    do_reset(1);
    @(negedge clk);
    pops = 0;
    hdr(4'd3, 16'd0);
    hdr(4'd6, 16'd257);
    for (int i = 0; i < 257; i++) word(32'hD000_0000 + i, 0, 0, 0, 0);
    hdr(4'd2, 16'd1);
    word(32'h77, 1, 1, 4'd2, 1);
    wait_idle("t4", 2000);
    chk("t4_err", err_cnt, 2);
    chk("t4_pkt", pkt_cnt, 1);
    chk("t4_pops", pops, 261);

    // FIFO empty toggling every cycle mid-packet.
    do_reset(1);
    @(negedge clk);
    gap_en = 1;
    hdr(4'd4, 16'd4);
    word(32'h50, 1, 0, 4'd4, 1);
    word(32'h51, 0, 0, 4'd4, 1);
    word(32'h52, 0, 0, 4'd4, 1);
    word(32'h53, 0, 1, 4'd4, 1);
    wait_idle("t5", 200);
    gap_en = 0;
    chk("t5_pkt", pkt_cnt, 1);

    // Reset mid-packet; leftover words parse as len=0 headers.
    do_reset(1);
    @(negedge clk);
    pops = 0;
    bus.out_ready = 1'b0;
    hdr(4'd7, 16'd4);
    word(32'h60, 0, 0, 0, 0);
    word(32'h61, 0, 0, 0, 0);
    word(32'h0003_0000, 0, 0, 0, 0);
    word(32'h0005_0000, 0, 0, 0, 0);
    n = 0;
    while (pops < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("t6_pops", pops, 3);
    chk("t6_rd_en", bus.in_rd_en, 0);
    do_reset(1);
    @(negedge clk);
    chk("t6_valid_after_rst", bus.out_valid, 0);
    hdr(4'd1, 16'd2);
    word(32'h88, 1, 0, 4'd1, 1);
    word(32'h99, 0, 1, 4'd1, 1);
    bus.out_ready = 1'b1;
    wait_idle("t6", 200);
    chk("t6_pkt", pkt_cnt, 1);
    chk("t6_err", err_cnt, 2);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
